approx_mul_seq: RTL and testbench
=================================

APPROX_MUL_SEQ -- requirements
Module: approx_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; even, 4..16.
REQ-002 SHALL have parameter APPROX_DIGITS, default WIDTH/2, count of low-order digit weights (i+j) eligible for approximate tiles; 0..WIDTH-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand offer.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-008 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-009 SHALL have port approx_en  input  1  selects approximate tiles; sampled with operands.
REQ-010 SHALL have port out_valid  output  1  product available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts product.
REQ-012 SHALL have port p  output  2*WIDTH  product.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL split a and b into D=WIDTH/2 two-bit digits a_i and b_j (digit 0 = LSBs).
REQ-015 SHALL evaluate one 2x2 tile (i,j) per CALC cycle, order j outer, i inner, and add tile<<(2*(i+j)) into a 2*WIDTH-bit accumulator; no overflow possible.
REQ-016 SHALL use the exact tile a_i*b_j unless approx_en was 1 at acceptance and i+j < APPROX_DIGITS.
REQ-017 Approximate tile SHALL be raw = 4*(x1&y1) + 2*(x0&y1) + (x0&y0), overridden to 9 for x=3,y=3 and to 2 for x=2,y=1. Result: x=3,y=1 gives 1; x=2,y=3 gives 4; all other pairs exact.
REQ-018 SHALL implement states IDLE, CALC, DONE.
REQ-019 IDLE: in_ready=1; in_valid=1 latches a, b, approx_en, clears accumulator and tile counter, next state CALC.
REQ-020 Zero skip: if latched a==0 or b==0, next state SHALL be DONE directly with p=0.
REQ-021 CALC: tile counter 0..D*D-1; after tile D*D-1 is accumulated, next state DONE. Latency from acceptance edge to out_valid = D*D+1 cycles (zero skip: 1 cycle).
REQ-022 DONE: out_valid=1, p holds accumulator, stable until out_ready=1; out_valid&out_ready returns to IDLE on that edge.
REQ-023 in_ready SHALL be 0 in CALC and DONE; in_valid there is ignored, no operand is captured.
REQ-024 Changes on a, b, approx_en after acceptance SHALL NOT affect the in-flight product.
REQ-025 Accept and hand-off SHALL NOT occur in the same cycle; minimum spacing between acceptances is D*D+2 cycles.
REQ-026 p SHALL be driven by a register; outside DONE p retains its last value.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, p=0, accumulator and counter 0, regardless of clk.
REQ-028 Reset mid-CALC or mid-DONE SHALL discard the operation; no out_valid follows reset release without a new acceptance.
REQ-029 First acceptance possible on the first rising edge with rst_n=1.

Verification
REQ-030 WIDTH=8, approx_en=0, a=255, b=255 -> out_valid 17 cycles after acceptance, p=65025.
REQ-031 WIDTH=4, approx_en=1, a=3, b=1 -> p=1; same operands approx_en=0 -> p=3.
REQ-032 WIDTH=8, APPROX_DIGITS=1, approx_en=1, a=0x0B, b=0x0E -> tile(0,0) approximate (3x2, exact) -> p=154; a=0x02, b=0x03 -> tile(0,0)=4 -> p=4.
REQ-033 a=0, b=200, any mode -> out_valid 1 cycle after acceptance, p=0.
REQ-034 out_ready held 0 for 5 cycles in DONE -> p, out_valid stable; in_valid pulses ignored; in_ready=0.
REQ-035 rst_n asserted during CALC tile 5 -> immediate IDLE, p=0; after release no out_valid until new in_valid.

Source files
------------

// File: rtl/approx_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_seq
// Purpose  : Sequential unsigned WIDTH x WIDTH multiplier that accumulates one
//            2x2-bit digit tile per cycle. Optionally replaces the tiles of the
//            APPROX_DIGITS lowest digit weights with a cheap approximate tile.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready, a, b, approx_en : operand handshake
//            out_valid/out_ready, p             : product handshake
//            busy                               : high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module approx_mul_seq #(
    parameter int WIDTH         = 8,
    parameter int APPROX_DIGITS = WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int c_DIGITS = WIDTH / 2;
    localparam int c_IW     = (c_DIGITS > 1) ? $clog2(c_DIGITS) : 1;
    localparam int c_PW     = 2 * WIDTH;
    localparam logic [c_IW-1:0] c_LAST   = c_IW'(c_DIGITS - 1);
    localparam logic [c_IW:0]   c_APPROX = (c_IW + 1)'(APPROX_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               approx_q, approx_d;
    logic [c_PW-1:0]    acc_q, acc_d;
    logic [c_PW-1:0]    p_q, p_d;
    // Tile counter split into digit indices: j outer, i inner.
    logic [c_IW-1:0]    i_q, i_d;
    logic [c_IW-1:0]    j_q, j_d;

    logic [c_IW:0]      w_dsum;
    logic [1:0]         w_x;
    logic [1:0]         w_y;
    logic [3:0]         w_tile_exact;
    logic [3:0]         w_tile_approx;
    logic [3:0]         w_tile;
    logic [c_PW-1:0]    w_tile_wide;
    logic [c_PW-1:0]    w_acc_next;

    // ------------------------------------------------------------------
    // Tile datapath
    // ------------------------------------------------------------------
    assign w_dsum       = {1'b0, i_q} + {1'b0, j_q};
    assign w_x          = a_q[{i_q, 1'b0} +: 2];
    assign w_y          = b_q[{j_q, 1'b0} +: 2];
    assign w_tile_exact = {2'b00, w_x} * {2'b00, w_y};

    // Approximate tile drops the x1&y0 partial product; two pairs are
    // patched back so only 3x1 and 2x3 remain inexact.
    always_comb begin
        w_tile_approx = {1'b0, w_x[1] & w_y[1], w_x[0] & w_y[1], w_x[0] & w_y[0]};
        if (w_x == 2'd3 && w_y == 2'd3) begin
            w_tile_approx = 4'd9;
        end else if (w_x == 2'd2 && w_y == 2'd1) begin
            w_tile_approx = 4'd2;
        end
    end

    assign w_tile      = (approx_q && (w_dsum < c_APPROX)) ? w_tile_approx : w_tile_exact;
    assign w_tile_wide = {{(c_PW-4){1'b0}}, w_tile} << {w_dsum, 1'b0};
    assign w_acc_next  = acc_q + w_tile_wide;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        approx_d = approx_q;
        acc_d    = acc_q;
        p_d      = p_q;
        i_d      = i_q;
        j_d      = j_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    approx_d = approx_en;
                    acc_d    = '0;
                    i_d      = '0;
                    j_d      = '0;
                    // A zero operand makes every tile zero; skip straight
                    // to the hand-off with a zero product.
                    if (a == '0 || b == '0) begin
                        state_d = ST_DONE;
                        p_d     = '0;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = w_acc_next;
                if (i_q == c_LAST) begin
                    i_d = '0;
                    if (j_q == c_LAST) begin
                        state_d = ST_DONE;
                        p_d     = w_acc_next;
                    end else begin
                        j_d = j_q + c_IW'(1);
                    end
                end else begin
                    i_d = i_q + c_IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            approx_q <= 1'b0;
            acc_q    <= '0;
            p_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            approx_q <= approx_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            i_q      <= i_d;
            j_q      <= j_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign p         = p_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_mul_seq
// Purpose  : Self-checking bench for approx_mul_seq (WIDTH=8, APPROX_DIGITS=4).
//            Products are predicted by a digit-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mul_seq;

    localparam int W  = 8;
    localparam int AD = 4;
    localparam int D  = W / 2;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           approx_en = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a         = '0;
    logic [W-1:0]   b         = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] p;

    int tests = 0;
    int fails = 0;

    approx_mul_seq #(.WIDTH(W), .APPROX_DIGITS(AD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sum of digit tiles, approximate tiles taken from the table
    // of inexact pairs (3x1 -> 1, 2x3 -> 4), all others exact.
    function automatic int model(input int av, input int bv, input int en);
        int sum = 0;
        for (int j = 0; j < D; j++) begin
            for (int i = 0; i < D; i++) begin
                int x = (av >> (2 * i)) & 3;
                int y = (bv >> (2 * j)) & 3;
                int t = x * y;
                if (en != 0 && (i + j) < AD) begin
                    if (x == 3 && y == 1)      t = 1;
                    else if (x == 2 && y == 3) t = 4;
                end
                sum += t * (1 << (2 * (i + j)));
            end
        end
        return sum;
    endfunction

    // Offer one operand pair, follow it to hand-off while wiggling the
    // inputs, optionally stall the consumer for 'hold' cycles.
    task automatic run_op(input int av, input int bv, input int en, input int hold);
        int exp_p;
        int lat;
        int edges;
        exp_p = model(av, bv, en);
        lat   = (av == 0 || bv == 0) ? 1 : D * D + 1;
        check("in_ready_idle", 32'(in_ready), 1);
        a = W'(av); b = W'(bv); approx_en = en[0]; in_valid = 1'b1;
        @(posedge clk); #1;
        edges = 1;     // the acceptance edge counts as cycle 1
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); approx_en = 1'($urandom);
        while (!out_valid && edges < 200) begin
            check("in_ready_calc", 32'(in_ready), 0);
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        check("latency", edges, lat);
        check("product", 32'(p), exp_p);
        check("busy_done", 32'(busy), 1);
        repeat (hold) begin
            in_valid = 1'($urandom);
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            check("p_stable", 32'(p), exp_p);
            check("out_valid_stall", 32'(out_valid), 1);
            check("in_ready_done", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after", 32'(out_valid), 0);
        check("in_ready_after", 32'(in_ready), 1);
        check("busy_after", 32'(busy), 0);
        check("p_retained", 32'(p), exp_p);
    endtask

    initial begin
        int av;
        int bv;
        // Reset values before any clock edge.
        #2;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_p", 32'(p), 0);
        #1 rst_n = 1'b1;

        // Directed cases, first one accepted on the first edge after release.
        run_op(255, 255, 0, 0);
        run_op(3, 1, 1, 0);
        run_op(3, 1, 0, 0);
        run_op(11, 14, 1, 0);
        run_op(2, 3, 1, 0);
        run_op(0, 200, 0, 0);
        run_op(0, 200, 1, 0);
        run_op(200, 0, 1, 5);
        run_op(37, 91, 1, 5);

        // Reset in the cycle that evaluates tile 5.
        a = 8'hAB; b = 8'hCD; approx_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_p", 32'(p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", 32'(out_valid), 0);
        end

        // Randomised operations.
        for (int k = 0; k < 20; k++) begin
            av = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            run_op(av, bv, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
